// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared stage encodings and sequencer state codes for rsa_top
package rsa_pkg;

    // Stage request/ready/init bit encodings (one-hot, bit0 = predict)
    localparam logic [2:0] STAGE_NONE = 3'b000;
    localparam logic [2:0] STAGE_PRD  = 3'b001;
    localparam logic [2:0] STAGE_NEW  = 3'b010;
    localparam logic [2:0] STAGE_UPD  = 3'b100;

    // Sequencer states; BUSY codes deliberately mirror the stage bits they serve
    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_BUSY_PRD = 3'b001,
        ST_BUSY_NEW = 3'b010,
        ST_BUSY_UPD = 3'b100
    } rsa_state_e;

    // Fixed-priority pick among granted stage bits: predict > new landmark > update
    function automatic logic [2:0] stage_pick(input logic [2:0] req);
        logic [2:0] pick;
        pick = STAGE_NONE;
        if (req[0])
            pick = STAGE_PRD;
        else if (req[1])
            pick = STAGE_NEW;
        else if (req[2])
            pick = STAGE_UPD;
        return pick;
    endfunction

endpackage

// File: rtl/rsa_top.sv
// rtl/rsa_top.sv - stage sequencer handing predict/new-landmark/update jobs to the compute engine
module rsa_top
    import rsa_pkg::*;
#(
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int L          = 4,
    parameter int RSA_DW     = 16,
    parameter int RSA_AW     = 17,
    parameter int TB_AW      = 11,
    parameter int CB_AW      = 17,
    parameter int SEQ_CNT_DW = 5,
    parameter int ROW_LEN    = 10
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic [2:0]          stage_val,
    input  logic [ROW_LEN-1:0]  landmark_num,
    input  logic [ROW_LEN-1:0]  l_k,
    input  logic                done_predict,
    input  logic                done_newlm,
    input  logic                done_update,
    input  logic [RSA_DW-1:0]   result_0,
    input  logic [RSA_DW-1:0]   result_1,
    input  logic [RSA_DW-1:0]   result_2,
    input  logic [RSA_DW-1:0]   result_3,
    input  logic [RSA_DW-1:0]   result_4,
    input  logic [RSA_DW-1:0]   result_5,
    output logic [2:0]          stage_rdy,
    output logic                init_predict,
    output logic                init_newlm,
    output logic                init_update,
    output logic [RSA_DW-1:0]   S_data,
    output logic [RSA_DW-1:0]   xk,
    output logic [RSA_DW-1:0]   yk,
    output logic [RSA_DW-1:0]   xita,
    output logic [RSA_DW-1:0]   lkx,
    output logic [RSA_DW-1:0]   lky
);

    // A degenerate array/address configuration leaves the sequencer permanently unready
    localparam bit CFG_OK = (X > 0) && (Y > 0) && (L > 0) && (RSA_DW > 0) &&
                            (RSA_AW > 0) && (TB_AW > 0) && (CB_AW > 0) &&
                            (SEQ_CNT_DW > 0) && (ROW_LEN > 0);

    rsa_state_e  state_q;
    rsa_state_e  state_d;
    logic [2:0]  init_q;
    logic [2:0]  init_d;
    logic [2:0]  grant;
    logic        upd_allowed;
    logic        ld_pose;
    logic        ld_lm;
    logic        ld_s;

    // Update is only meaningful for a landmark that already exists
    assign upd_allowed = (l_k < landmark_num);

    // Ready only while idle; the update bit follows the landmark index live
    assign stage_rdy = ((state_q == ST_IDLE) && CFG_OK) ? {upd_allowed, 2'b11} : STAGE_NONE;

    assign grant = stage_pick(stage_val & stage_rdy);

    assign init_predict = init_q[0];
    assign init_newlm   = init_q[1];
    assign init_update  = init_q[2];

    // Next-state, start-pulse and result-load decode
    always_comb begin
        state_d = state_q;
        init_d  = STAGE_NONE;
        ld_pose = 1'b0;
        ld_lm   = 1'b0;
        ld_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                init_d = grant;
                case (grant)
                    STAGE_PRD: state_d = ST_BUSY_PRD;
                    STAGE_NEW: state_d = ST_BUSY_NEW;
                    STAGE_UPD: state_d = ST_BUSY_UPD;
                    default:   state_d = ST_IDLE;
                endcase
            end
            ST_BUSY_PRD: begin
                if (done_predict) begin
                    ld_pose = 1'b1;
                    ld_s    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_NEW: begin
                if (done_newlm) begin
                    ld_lm   = 1'b1;
                    ld_s    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_UPD: begin
                if (done_update) begin
                    ld_pose = 1'b1;
                    ld_lm   = 1'b1;
                    ld_s    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and one-cycle start pulses
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            init_q  <= STAGE_NONE;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
        end
    end

    // Capture engine results into the robot pose / landmark / S registers
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            S_data <= '0;
            xk     <= '0;
            yk     <= '0;
            xita   <= '0;
            lkx    <= '0;
            lky    <= '0;
        end else begin
            if (ld_s) begin
                S_data <= result_0;
            end
            if (ld_pose) begin
                xk   <= result_1;
                yk   <= result_2;
                xita <= result_3;
            end
            if (ld_lm) begin
                lkx <= result_4;
                lky <= result_5;
            end
        end
    end

endmodule

// File: tb/tb_rsa_top.sv
// tb/tb_rsa_top.sv - self-checking bench for rsa_top with a behavioural stage model
module tb_rsa_top;
    import rsa_pkg::*;

    localparam int DW = 16;
    localparam int RL = 10;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [2:0]    stage_val;
    logic [RL-1:0] landmark_num;
    logic [RL-1:0] l_k;
    logic          done_predict, done_newlm, done_update;
    logic [DW-1:0] result_0, result_1, result_2, result_3, result_4, result_5;
    logic [2:0]    stage_rdy;
    logic          init_predict, init_newlm, init_update;
    logic [DW-1:0] S_data, xk, yk, xita, lkx, lky;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rsa_top dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .stage_val    (stage_val),
        .landmark_num (landmark_num),
        .l_k          (l_k),
        .done_predict (done_predict),
        .done_newlm   (done_newlm),
        .done_update  (done_update),
        .result_0     (result_0),
        .result_1     (result_1),
        .result_2     (result_2),
        .result_3     (result_3),
        .result_4     (result_4),
        .result_5     (result_5),
        .stage_rdy    (stage_rdy),
        .init_predict (init_predict),
        .init_newlm   (init_newlm),
        .init_update  (init_update),
        .S_data       (S_data),
        .xk           (xk),
        .yk           (yk),
        .xita         (xita),
        .lkx          (lkx),
        .lky          (lky)
    );

    // Reference model: which job is outstanding (0 none, 1 predict, 2 new landmark, 3 update)
    int            m_job = 0;
    logic [2:0]    m_init = 3'b000;
    logic [DW-1:0] m_s = '0, m_xk = '0, m_yk = '0, m_xita = '0, m_lkx = '0, m_lky = '0;

    always @(posedge clk) begin
        if (sys_rst) begin
            m_job  <= 0;
            m_init <= 3'b000;
            m_s <= '0; m_xk <= '0; m_yk <= '0; m_xita <= '0; m_lkx <= '0; m_lky <= '0;
        end else begin
            m_init <= 3'b000;
            if (m_job == 0) begin
                if (stage_val[0]) begin
                    m_job <= 1; m_init <= 3'b001;
                end else if (stage_val[1]) begin
                    m_job <= 2; m_init <= 3'b010;
                end else if (stage_val[2] && (int'(l_k) < int'(landmark_num))) begin
                    m_job <= 3; m_init <= 3'b100;
                end
            end else if (m_job == 1 && done_predict) begin
                m_job <= 0;
                m_s <= result_0; m_xk <= result_1; m_yk <= result_2; m_xita <= result_3;
            end else if (m_job == 2 && done_newlm) begin
                m_job <= 0;
                m_s <= result_0; m_lkx <= result_4; m_lky <= result_5;
            end else if (m_job == 3 && done_update) begin
                m_job <= 0;
                m_s <= result_0; m_xk <= result_1; m_yk <= result_2; m_xita <= result_3;
                m_lkx <= result_4; m_lky <= result_5;
            end
        end
    end

    function automatic logic [2:0] model_rdy();
        if (m_job != 0)
            return 3'b000;
        return {(int'(l_k) < int'(landmark_num)), 2'b11};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_results(input logic [DW-1:0] r0, r1, r2, r3, r4, r5);
        result_0 = r0; result_1 = r1; result_2 = r2;
        result_3 = r3; result_4 = r4; result_5 = r5;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        stage_val = 3'b111;
        done_predict = 1'b1; done_newlm = 1'b1; done_update = 1'b1;
        set_results('1, '1, '1, '1, '1, '1);
        l_k = 10'd5; landmark_num = 10'd6;
        tick();
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict} !== 3'b000) begin
            failures++;
            $display("FAIL reset_init got=%b want=000", {init_update, init_newlm, init_predict});
        end
        checks++;
        if ({S_data, xk, yk, xita, lkx, lky} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {S_data, xk, yk, xita, lkx, lky});
        end
        checks++;
        if (stage_rdy !== 3'b111) begin
            failures++;
            $display("FAIL reset_rdy got=%b want=111", stage_rdy);
        end
        sys_rst = 1'b0;
        stage_val = STAGE_NONE;
        done_predict = 1'b0; done_newlm = 1'b0; done_update = 1'b0;
    endtask

    task automatic test_predict();
        stage_val = STAGE_PRD;
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b001_000) begin
            failures++;
            $display("FAIL prd_accept got=%b want=001000", {init_update, init_newlm, init_predict, stage_rdy});
        end
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b000_000) begin
            failures++;
            $display("FAIL prd_held got=%b want=000000", {init_update, init_newlm, init_predict, stage_rdy});
        end
        stage_val = STAGE_NONE;
        set_results(16'd7, 16'd1, 16'd2, 16'd3, 16'hEE, 16'hEF);
        done_predict = 1'b1;
        tick();
        done_predict = 1'b0;
        checks++;
        if ({S_data, xk, yk, xita, lkx, lky} !== {16'd7, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL prd_done got=%h want=%h", {S_data, xk, yk, xita, lkx, lky},
                     {16'd7, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0});
        end
        checks++;
        if (stage_rdy !== 3'b111) begin
            failures++;
            $display("FAIL prd_rdy got=%b want=111", stage_rdy);
        end
    endtask

    task automatic test_update_gate();
        l_k = 10'd6; landmark_num = 10'd6;
        stage_val = STAGE_UPD;
        #1;
        checks++;
        if (stage_rdy !== 3'b011) begin
            failures++;
            $display("FAIL upd_gate_rdy got=%b want=011", stage_rdy);
        end
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b000_011) begin
            failures++;
            $display("FAIL upd_gate_block got=%b want=000011", {init_update, init_newlm, init_predict, stage_rdy});
        end
        l_k = 10'd5;
        #1;
        checks++;
        if (stage_rdy !== 3'b111) begin
            failures++;
            $display("FAIL upd_open_rdy got=%b want=111", stage_rdy);
        end
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict} !== 3'b100) begin
            failures++;
            $display("FAIL upd_accept got=%b want=100", {init_update, init_newlm, init_predict});
        end
        stage_val = STAGE_NONE;
        set_results(16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15);
        done_update = 1'b1;
        tick();
        done_update = 1'b0;
        checks++;
        if ({S_data, xk, yk, xita, lkx, lky} !== {16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15}) begin
            failures++;
            $display("FAIL upd_done got=%h want=%h", {S_data, xk, yk, xita, lkx, lky},
                     {16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15});
        end
    endtask

    task automatic test_newlm_same_cycle();
        stage_val = STAGE_NEW;
        tick();
        checks++;
        if ({init_update, init_newlm, init_predict} !== 3'b010) begin
            failures++;
            $display("FAIL new_accept got=%b want=010", {init_update, init_newlm, init_predict});
        end
        stage_val = STAGE_NONE;
        set_results(16'hA0, 16'hB1, 16'hB2, 16'hB3, 16'hA4, 16'hA5);
        done_newlm = 1'b1;
        tick();
        done_newlm = 1'b0;
        checks++;
        if ({S_data, xk, yk, xita, lkx, lky} !== {16'hA0, 16'd11, 16'd12, 16'd13, 16'hA4, 16'hA5}) begin
            failures++;
            $display("FAIL new_same_cycle got=%h want=%h", {S_data, xk, yk, xita, lkx, lky},
                     {16'hA0, 16'd11, 16'd12, 16'd13, 16'hA4, 16'hA5});
        end
    endtask

    task automatic test_priority();
        stage_val = 3'b111;
        tick();
        stage_val = STAGE_NONE;
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b001_000) begin
            failures++;
            $display("FAIL priority got=%b want=001000", {init_update, init_newlm, init_predict, stage_rdy});
        end
    endtask

    task automatic test_stray_done();
        set_results(16'd99, 16'd98, 16'd97, 16'd96, 16'd9, 16'd8);
        done_update = 1'b1;
        tick();
        done_update = 1'b0;
        checks++;
        if ({S_data, lkx, lky, stage_rdy} !== {16'hA0, 16'hA4, 16'hA5, 3'b000}) begin
            failures++;
            $display("FAIL stray_upd got=%h want=%h", {S_data, lkx, lky, stage_rdy}, {16'hA0, 16'hA4, 16'hA5, 3'b000});
        end
        done_newlm = 1'b1;
        tick();
        done_newlm = 1'b0;
        checks++;
        if ({lkx, lky, stage_rdy} !== {16'hA4, 16'hA5, 3'b000}) begin
            failures++;
            $display("FAIL stray_new got=%h want=%h", {lkx, lky, stage_rdy}, {16'hA4, 16'hA5, 3'b000});
        end
        set_results(16'hC0, 16'hC1, 16'hC2, 16'hC3, 16'hC4, 16'hC5);
        done_predict = 1'b1;
        tick();
        done_predict = 1'b0;
        checks++;
        if ({S_data, xk, yk, xita, lkx, stage_rdy} !== {16'hC0, 16'hC1, 16'hC2, 16'hC3, 16'hA4, 3'b111}) begin
            failures++;
            $display("FAIL prd_after_stray got=%h want=%h", {S_data, xk, yk, xita, lkx, stage_rdy},
                     {16'hC0, 16'hC1, 16'hC2, 16'hC3, 16'hA4, 3'b111});
        end
        set_results('1, '1, '1, '1, '1, '1);
        done_update = 1'b1; done_predict = 1'b1; done_newlm = 1'b1;
        tick();
        done_update = 1'b0; done_predict = 1'b0; done_newlm = 1'b0;
        checks++;
        if ({S_data, xk, lkx, init_update, init_newlm, init_predict, stage_rdy} !==
            {16'hC0, 16'hC1, 16'hA4, 3'b000, 3'b111}) begin
            failures++;
            $display("FAIL idle_done got=%h want=%h", {S_data, xk, lkx, init_update, init_newlm, init_predict, stage_rdy},
                     {16'hC0, 16'hC1, 16'hA4, 3'b000, 3'b111});
        end
    endtask

    task automatic test_back_to_back();
        stage_val = STAGE_PRD;
        tick();
        stage_val = STAGE_NEW;
        done_predict = 1'b1;
        tick();
        done_predict = 1'b0;
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b000_111) begin
            failures++;
            $display("FAIL b2b_return got=%b want=000111", {init_update, init_newlm, init_predict, stage_rdy});
        end
        tick();
        stage_val = STAGE_NONE;
        checks++;
        if ({init_update, init_newlm, init_predict, stage_rdy} !== 6'b010_000) begin
            failures++;
            $display("FAIL b2b_accept got=%b want=010000", {init_update, init_newlm, init_predict, stage_rdy});
        end
    endtask

    task automatic test_reset_mid_stage();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        checks++;
        if ({S_data, xk, yk, xita, lkx, lky} !== 96'd0 || stage_rdy !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b want=0/111", {S_data, xk, yk, xita, lkx, lky}, stage_rdy);
        end
        set_results(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        done_newlm = 1'b1;
        tick();
        done_newlm = 1'b0;
        checks++;
        if ({lkx, lky, S_data, init_update, init_newlm, init_predict, stage_rdy} !== {48'd0, 6'b000_111}) begin
            failures++;
            $display("FAIL late_done got=%h want=%h", {lkx, lky, S_data, init_update, init_newlm, init_predict, stage_rdy},
                     {48'd0, 6'b000_111});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sys_rst      = ($urandom_range(0, 40) == 0);
            stage_val    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : STAGE_NONE;
            done_predict = ($urandom_range(0, 3) == 0);
            done_newlm   = ($urandom_range(0, 3) == 0);
            done_update  = ($urandom_range(0, 3) == 0);
            l_k          = RL'($urandom_range(0, 12));
            landmark_num = RL'($urandom_range(0, 12));
            set_results(DW'($urandom), DW'($urandom), DW'($urandom),
                        DW'($urandom), DW'($urandom), DW'($urandom));
            #1;
            checks++;
            if (stage_rdy !== model_rdy()) begin
                failures++;
                $display("FAIL rnd_rdy cycle=%0d got=%b want=%b", i, stage_rdy, model_rdy());
            end
            tick();
            checks++;
            if ({init_update, init_newlm, init_predict} !== m_init) begin
                failures++;
                $display("FAIL rnd_init cycle=%0d got=%b want=%b", i, {init_update, init_newlm, init_predict}, m_init);
            end
            checks++;
            if ({S_data, xk, yk, xita, lkx, lky} !== {m_s, m_xk, m_yk, m_xita, m_lkx, m_lky}) begin
                failures++;
                $display("FAIL rnd_data cycle=%0d got=%h want=%h", i, {S_data, xk, yk, xita, lkx, lky},
                         {m_s, m_xk, m_yk, m_xita, m_lkx, m_lky});
            end
        end
        sys_rst = 1'b0;
        stage_val = STAGE_NONE;
        done_predict = 1'b0; done_newlm = 1'b0; done_update = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1;
        stage_val = STAGE_NONE;
        done_predict = 1'b0; done_newlm = 1'b0; done_update = 1'b0;
        l_k = '0; landmark_num = '0;
        set_results('0, '0, '0, '0, '0, '0);
        test_reset();
        test_predict();
        test_update_gate();
        test_newlm_same_cycle();
        test_priority();
        test_stray_done();
        test_back_to_back();
        test_reset_mid_stage();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
